// File: rtl/booth_ctrl.sv
// Radix-2 Booth sequencer: takes a Start/Ack handshake and steps the mult
// datapath through N_LEN evaluate/shift iterations, raising Done when finished.
module booth_ctrl #(
  parameter int N_LEN = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         Ack,
  input  logic [2:0]                   Q_out,
  output logic                         Request,
  output logic                         add_s,
  output logic                         sub_s,
  output logic                         ashift_s,
  output logic                         Done,
  output logic                         Busy,
  output logic [$clog2(N_LEN+1)-1:0]   Count
);

  localparam int CW = $clog2(N_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next_count;

  // Q_out[2] is part of the datapath bus but carries nothing Booth needs.
  logic w_unused;
  assign w_unused = Q_out[2];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    Request      = 1'b0;
    add_s        = 1'b0;
    sub_s        = 1'b0;
    ashift_s     = 1'b0;
    Done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_next_state = S_LOAD;
          w_next_count = CW'(N_LEN);
        end
      end
      S_LOAD: begin
        Request      = 1'b1;
        w_next_state = S_EVAL;
      end
      S_EVAL: begin
        // {Q[0],Q[-1]}: 10 starts a run of ones (subtract), 01 ends one (add)
        sub_s        = (Q_out[1:0] == 2'b10);
        add_s        = (Q_out[1:0] == 2'b01);
        w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        ashift_s = 1'b1;
        if (r_count != '0)
          w_next_count = r_count - CW'(1);
        if (r_count <= CW'(1))
          w_next_state = S_DONE;
        else
          w_next_state = S_EVAL;
      end
      S_DONE: begin
        Done = 1'b1;
        if (Ack)
          w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign Busy  = (r_state != S_IDLE);
  assign Count = r_count;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: a behavioural Booth datapath closes the loop and
// every product is compared against plain signed multiplication.
module tb_booth_ctrl;
  localparam int N = 8;

  logic       Clock = 1'b0;
  logic       Reset, Start, Ack;
  logic [2:0] Q_out;
  logic       Request, add_s, sub_s, ashift_s, Done, Busy;
  logic [3:0] Count;

  int n_pass = 0;
  int n_total = 0;

  booth_ctrl #(.N_LEN(N)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Ack(Ack), .Q_out(Q_out),
    .Request(Request), .add_s(add_s), .sub_s(sub_s), .ashift_s(ashift_s),
    .Done(Done), .Busy(Busy), .Count(Count)
  );

  always #5 Clock = ~Clock;

  // Datapath stand-in; A carries a guard bit so M=-128 subtracts cleanly.
  logic signed [7:0] op1, op2;
  logic [8:0] dp_a, dp_m;
  logic [7:0] dp_q;
  logic       dp_qm1, dp_q2;
  logic       c_req = 0, c_add = 0, c_sub = 0, c_sh = 0;
  logic       q_force_en = 0;
  logic [2:0] q_force = '0;

  always @(negedge Clock) begin
    c_req <= Request; c_add <= add_s; c_sub <= sub_s; c_sh <= ashift_s;
  end

  always @(posedge Clock) begin
    dp_q2 <= 1'($urandom);
    if (c_req) begin
      dp_m <= {op1[7], op1}; dp_q <= op2; dp_a <= '0; dp_qm1 <= 1'b0;
    end else if (c_add) dp_a <= dp_a + dp_m;
    else if (c_sub) dp_a <= dp_a - dp_m;
    else if (c_sh) {dp_a, dp_q, dp_qm1} <= {dp_a[8], dp_a, dp_q};
  end

  assign Q_out = q_force_en ? q_force : {dp_q2, dp_q[0], dp_qm1};

  // Observations from the last operation
  int         o_add, o_sub, o_sh, o_req, o_lat, o_oh;
  bit         o_tmo;
  logic [3:0] o_load_cnt;
  logic [3:0] cnt_log[$];
  logic [15:0] o_res;

  function automatic void ref_pulses(input logic [7:0] b, output int na, output int ns);
    logic prev = 1'b0;
    na = 0; ns = 0;
    for (int i = 0; i < N; i++) begin
      if (b[i] && !prev) ns++;
      if (!b[i] && prev) na++;
      prev = b[i];
    end
  endfunction

  task automatic do_op(input logic signed [7:0] a, input logic signed [7:0] b, input bit disturb);
    op1 = a; op2 = b;
    o_add = 0; o_sub = 0; o_sh = 0; o_req = 0; o_lat = -1; o_oh = 0; o_tmo = 0;
    cnt_log.delete();
    @(negedge Clock); Start = 1; Ack = 0;
    @(negedge Clock); Start = 0;
    for (int e = 0; e < 100; e++) begin
      if (e > 0) @(negedge Clock);
      if (e == 0) o_load_cnt = Count;
      if (Request) o_req++;
      if (add_s) o_add++;
      if (sub_s) o_sub++;
      if (ashift_s) begin o_sh++; cnt_log.push_back(Count); end
      if ($countones({Request, add_s, sub_s, ashift_s}) > 1) o_oh++;
      if (Done) begin o_lat = e; o_res = {dp_a[7:0], dp_q}; break; end
      if (disturb) begin
        Start = (e == 3 || e == 6 || e == 11);
        Ack   = (e == 5 || e == 8 || e == 12);
      end
    end
    Start = 0; Ack = 0;
    if (o_lat < 0) o_tmo = 1;
  endtask

  task automatic ack_done();
    @(negedge Clock); Ack = 1;
    @(negedge Clock); Ack = 0;
  endtask

  task automatic test_reset();
    n_total++; if ({Request, add_s, sub_s, ashift_s, Done, Busy} !== 6'b0) $display("FAIL reset_outs: got %b exp 000000", {Request, add_s, sub_s, ashift_s, Done, Busy}); else n_pass++;
    n_total++; if (Count !== 4'd0) $display("FAIL reset_count: got %0d exp 0", Count); else n_pass++;
  endtask

  task automatic test_basic();
    do_op(8'sd15, 8'sd23, 0);
    n_total++; if (o_tmo !== 1'b0) $display("FAIL basic_timeout: got %0d exp 0", o_tmo); else n_pass++;
    n_total++; if (o_lat !== 17) $display("FAIL basic_latency: got %0d exp 17", o_lat); else n_pass++;
    n_total++; if (o_sub !== 2 || o_add !== 2) $display("FAIL basic_addsub: got sub=%0d add=%0d exp 2 2", o_sub, o_add); else n_pass++;
    n_total++; if (o_sh !== 8 || o_req !== 1) $display("FAIL basic_shift_req: got sh=%0d req=%0d exp 8 1", o_sh, o_req); else n_pass++;
    n_total++; if (o_res !== 16'h0159) $display("FAIL basic_result: got %h exp 0159", o_res); else n_pass++;
    n_total++; if (o_oh !== 0) $display("FAIL basic_onehot: got %0d exp 0", o_oh); else n_pass++;
    repeat (3) begin
      @(negedge Clock);
      n_total++; if (Done !== 1'b1 || Busy !== 1'b1) $display("FAIL basic_hold: got done=%b busy=%b exp 1 1", Done, Busy); else n_pass++;
    end
    ack_done();
    n_total++; if (Done !== 1'b0 || Busy !== 1'b0) $display("FAIL basic_ack: got done=%b busy=%b exp 0 0", Done, Busy); else n_pass++;
  endtask

  task automatic test_corners();
    do_op(-8'sd128, -8'sd128, 0);
    n_total++; if (o_res !== 16'h4000 || o_lat !== 17) $display("FAIL corner_m128: got %h lat=%0d exp 4000 17", o_res, o_lat); else n_pass++;
    ack_done();
    do_op(8'sd7, -8'sd1, 0);
    n_total++; if (o_res !== 16'hFFF9) $display("FAIL corner_m1_res: got %h exp fff9", o_res); else n_pass++;
    n_total++; if (o_sub !== 1 || o_add !== 0) $display("FAIL corner_m1_pulses: got sub=%0d add=%0d exp 1 0", o_sub, o_add); else n_pass++;
    ack_done();
  endtask

  task automatic test_zero();
    do_op(8'sd93, 8'sd0, 0);
    n_total++; if (o_add !== 0 || o_sub !== 0 || o_sh !== 8) $display("FAIL zero_pulses: got add=%0d sub=%0d sh=%0d exp 0 0 8", o_add, o_sub, o_sh); else n_pass++;
    n_total++; if (o_res !== 16'h0000) $display("FAIL zero_result: got %h exp 0000", o_res); else n_pass++;
    n_total++; if (o_load_cnt !== 4'd8) $display("FAIL zero_load_count: got %0d exp 8", o_load_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (i >= cnt_log.size() || cnt_log[i] !== 4'(8 - i)) $display("FAIL zero_count_step%0d: got %0d exp %0d", i, (i < cnt_log.size()) ? cnt_log[i] : 4'hx, 8 - i); else n_pass++;
    end
    n_total++; if (Count !== 4'd0) $display("FAIL zero_count_done: got %0d exp 0", Count); else n_pass++;
    ack_done();
  endtask

  task automatic test_disturb();
    do_op(8'sd15, 8'sd23, 1);
    n_total++; if (o_lat !== 17 || o_sh !== 8) $display("FAIL disturb_timing: got lat=%0d sh=%0d exp 17 8", o_lat, o_sh); else n_pass++;
    n_total++; if (o_sub !== 2 || o_add !== 2 || o_req !== 1) $display("FAIL disturb_pulses: got sub=%0d add=%0d req=%0d exp 2 2 1", o_sub, o_add, o_req); else n_pass++;
    n_total++; if (o_res !== 16'h0159) $display("FAIL disturb_result: got %h exp 0159", o_res); else n_pass++;
    ack_done();
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    op1 = 8'sd15; op2 = 8'sd23;
    @(negedge Clock); Start = 1;
    @(negedge Clock); Start = 0;
    repeat (9) @(negedge Clock);
    #2 Reset = 1;
    #1;
    n_total++; if ({Request, add_s, sub_s, ashift_s, Done, Busy} !== 6'b0 || Count !== 4'd0) $display("FAIL midreset_outs: got %b cnt=%0d exp 000000 0", {Request, add_s, sub_s, ashift_s, Done, Busy}, Count); else n_pass++;
    @(negedge Clock); Reset = 0;
    repeat (20) begin
      @(negedge Clock);
      if (Done || Busy) seen_done++;
    end
    n_total++; if (seen_done !== 0) $display("FAIL midreset_idle: got %0d busy/done cycles exp 0", seen_done); else n_pass++;
    do_op(-8'sd50, 8'sd77, 0);
    n_total++; if (o_res !== 16'(-50 * 77) || o_lat !== 17) $display("FAIL midreset_rerun: got %h lat=%0d exp %h 17", o_res, o_lat, 16'(-50 * 77)); else n_pass++;
    ack_done();
  endtask

  task automatic test_start_ack_done();
    do_op(8'sd3, 8'sd5, 0);
    @(negedge Clock); Start = 1; Ack = 1;
    @(negedge Clock); Start = 0; Ack = 0;
    n_total++; if (Busy !== 1'b0 || Done !== 1'b0 || Request !== 1'b0) $display("FAIL startack_idle: got busy=%b done=%b req=%b exp 0 0 0", Busy, Done, Request); else n_pass++;
    repeat (3) begin
      @(negedge Clock);
      n_total++; if (Busy !== 1'b0 || Request !== 1'b0) $display("FAIL startack_noload: got busy=%b req=%b exp 0 0", Busy, Request); else n_pass++;
    end
  endtask

  task automatic test_start_held();
    int lat = -1;
    do_op(-8'sd9, 8'sd11, 0);
    @(negedge Clock); Start = 1; Ack = 1;
    @(negedge Clock); Ack = 0;
    n_total++; if (Busy !== 1'b0) $display("FAIL held_idle: got busy=%b exp 0", Busy); else n_pass++;
    @(negedge Clock); Start = 0;
    n_total++; if (Request !== 1'b1) $display("FAIL held_load: got req=%b exp 1", Request); else n_pass++;
    for (int e = 1; e < 60; e++) begin
      @(negedge Clock);
      if (Done) begin lat = e; break; end
    end
    n_total++; if (lat !== 17 || {dp_a[7:0], dp_q} !== 16'(-9 * 11)) $display("FAIL held_result: got %h lat=%0d exp %h 17", {dp_a[7:0], dp_q}, lat, 16'(-9 * 11)); else n_pass++;
    ack_done();
  endtask

  task automatic test_qout_ignored();
    int bad = 0;
    q_force_en = 1;
    repeat (12) begin
      q_force = 3'($urandom);
      @(negedge Clock);
      if (add_s || sub_s || Busy) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL qout_idle: got %0d active cycles exp 0", bad); else n_pass++;
    q_force_en = 0;
    do_op(8'sd21, 8'sd42, 0);
    q_force_en = 1;
    bad = 0;
    repeat (12) begin
      q_force = 3'($urandom);
      @(negedge Clock);
      if (add_s || sub_s || !Done) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL qout_done: got %0d bad cycles exp 0", bad); else n_pass++;
    q_force_en = 0;
    ack_done();
  endtask

  task automatic test_random();
    logic signed [7:0] a, b;
    logic signed [15:0] p;
    int ea, es, bad = 0;
    for (int k = 0; k < 24; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      p = a * b;
      ref_pulses(b, ea, es);
      do_op(a, b, 1'($urandom));
      if (o_tmo || o_res !== p || o_lat !== 17 || o_add !== ea || o_sub !== es || o_sh !== 8 || o_oh !== 0) begin
        bad++;
        $display("FAIL random_op%0d: %0d*%0d got res=%h lat=%0d add=%0d sub=%0d sh=%0d oh=%0d exp res=%h lat=17 add=%0d sub=%0d sh=8 oh=0",
                 k, a, b, o_res, o_lat, o_add, o_sub, o_sh, o_oh, p, ea, es);
      end
      ack_done();
    end
    n_total++; if (bad !== 0) $display("FAIL random_summary: got %0d bad ops exp 0", bad); else n_pass++;
  endtask

  initial begin
    Reset = 1; Start = 0; Ack = 0;
    repeat (2) @(negedge Clock);
    test_reset();
    Reset = 0;
    @(negedge Clock);
    test_basic();
    test_corners();
    test_zero();
    test_disturb();
    test_reset_mid();
    test_start_ack_done();
    test_start_held();
    test_qout_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
